// File: rtl/nn_inference_sequencer.sv
// nn_inference_sequencer
//   Sequences single inferences on an external network core and keeps a short
//   history of predicted classes, shown on active-low 7-segment digits.
//
//   clk          : single clock, rising edge
//   resetn       : asynchronous active-low reset
//   start_req    : asynchronous switch level; rising edge starts an inference
//   clear        : synchronous request to empty the history (IDLE/ERROR only)
//   nn_done      : inference-complete level from the core
//   nn_argmax    : predicted class, sampled when nn_done is high in WAIT
//   nn_start     : one-cycle start pulse to the core
//   busy         : high while ARM or WAIT
//   timeout_err  : sticky timeout flag, cleared by start or clear in ERROR
//   result_count : occupied history slots, saturating at HIST_DEPTH
//   hex_out      : 7 segments per slot, slot k at [7k+6:7k], slot 0 newest

// Per-slot segment decoder. Empty slots are blank; out-of-range classes show
// a dash; 0-15 use decimal/hex glyphs.
module nn_seg_decode #(
  parameter int NUM_CLASSES = 10,
  parameter int CLASS_W     = 4
) (
  input  logic               occ_i,
  input  logic [CLASS_W-1:0] val_i,
  output logic [6:0]         seg_o
);
  logic [3:0] v4;

  always_comb begin
    seg_o = 7'b1111111;
    v4    = 4'(val_i);
    if (occ_i) begin
      if (32'(val_i) >= 32'(NUM_CLASSES)) seg_o = 7'b0111111;
      else begin
        case (v4)
          4'd0:  seg_o = 7'b1000000;
          4'd1:  seg_o = 7'b1111001;
          4'd2:  seg_o = 7'b0100100;
          4'd3:  seg_o = 7'b0110000;
          4'd4:  seg_o = 7'b0011001;
          4'd5:  seg_o = 7'b0010010;
          4'd6:  seg_o = 7'b0000010;
          4'd7:  seg_o = 7'b1111000;
          4'd8:  seg_o = 7'b0000000;
          4'd9:  seg_o = 7'b0010000;
          4'd10: seg_o = 7'b0001000;
          4'd11: seg_o = 7'b0000011;
          4'd12: seg_o = 7'b1000110;
          4'd13: seg_o = 7'b0100001;
          4'd14: seg_o = 7'b0000110;
          default: seg_o = 7'b0001110;
        endcase
      end
    end
  end
endmodule

module nn_inference_sequencer #(
  parameter int NUM_CLASSES    = 10,
  parameter int CLASS_W        = 4,
  parameter int HIST_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start_req,
  input  logic                    clear,
  input  logic                    nn_done,
  input  logic [CLASS_W-1:0]      nn_argmax,
  output logic                    nn_start,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [2:0]              result_count,
  output logic [7*HIST_DEPTH-1:0] hex_out
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       CNT_SAT  = 3'(HIST_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_WAIT, S_CAPTURE, S_ERROR} state_e;

  state_e state_q, state_d;

  // Start synchronizer + edge detect. vld_pipe_q marks when the synchronizer
  // holds real samples; armed_q only sets once a settled low has been seen,
  // so a switch already high at reset release cannot fire a start.
  logic       sync1_q, sync2_q, prev_q, armed_q;
  logic [1:0] vld_pipe_q;
  logic       start_evt;

  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [CLASS_W-1:0]                 argmax_q;
  logic [HIST_DEPTH-1:0]              occ_q, occ_d;
  logic [HIST_DEPTH-1:0][CLASS_W-1:0] val_q, val_d;
  logic [2:0]                         count_q, count_d;
  logic                               err_q, err_d;

  assign start_evt = sync2_q & ~prev_q & armed_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      sync1_q    <= start_req;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      vld_pipe_q <= {vld_pipe_q[0], 1'b1};
      armed_q    <= armed_q | (vld_pipe_q[1] & ~sync2_q);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      argmax_q <= '0;
      occ_q    <= '0;
      val_q    <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      occ_q   <= occ_d;
      val_q   <= val_d;
      count_q <= count_d;
      err_q   <= err_d;
      // Class is latched on the WAIT exit so CAPTURE does not depend on
      // nn_argmax still being held by the core.
      if (state_q == S_WAIT && nn_done) argmax_q <= nn_argmax;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    occ_d    = occ_q;
    val_d    = val_q;
    count_d  = count_q;
    err_d    = err_q;
    nn_start = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Clear and start may coincide: history empties and ARM still follows.
        if (clear) begin
          occ_d   = '0;
          val_d   = '0;
          count_d = '0;
        end
        if (start_evt) state_d = S_ARM;
      end
      S_ARM: begin
        nn_start = 1'b1;
        busy     = 1'b1;
        cnt_d    = '0;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        // done has priority over the last timeout cycle
        if (nn_done) state_d = S_CAPTURE;
        else if (cnt_q == CNT_LAST) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_CAPTURE: begin
        for (int k = HIST_DEPTH - 1; k >= 1; k--) begin
          occ_d[k] = occ_q[k-1];
          val_d[k] = val_q[k-1];
        end
        occ_d[0] = 1'b1;
        val_d[0] = argmax_q;
        if (count_q != CNT_SAT) count_d = count_q + 3'd1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        if (clear) begin
          occ_d   = '0;
          val_d   = '0;
          count_d = '0;
        end
        if (start_evt) begin
          err_d   = 1'b0;
          state_d = S_ARM;
        end else if (clear) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign timeout_err  = err_q;
  assign result_count = count_q;

  for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_slot
    nn_seg_decode #(
      .NUM_CLASSES (NUM_CLASSES),
      .CLASS_W     (CLASS_W)
    ) u_dec (
      .occ_i (occ_q[k]),
      .val_i (val_q[k]),
      .seg_o (hex_out[7*k +: 7])
    );
  end
endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Scoreboard bench: each nn_done drive pushes the expected class; the value is
// popped and compared against slot 0 once the sequencer has captured it, and a
// small history model checks the full display and the count.
module tb_nn_inference_sequencer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_req = 1'b0;
  logic        clear = 1'b0;
  logic        nn_done = 1'b0;
  logic [3:0]  nn_argmax = '0;
  logic        nn_start, busy, timeout_err;
  logic [2:0]  result_count;
  logic [27:0] hex_out;

  nn_inference_sequencer #(
    .NUM_CLASSES    (10),
    .CLASS_W        (4),
    .HIST_DEPTH     (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .start_req    (start_req),
    .clear        (clear),
    .nn_done      (nn_done),
    .nn_argmax    (nn_argmax),
    .nn_start     (nn_start),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .result_count (result_count),
    .hex_out      (hex_out)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int start_cnt = 0, starts_exp = 0;
  logic [3:0] exp_q[$];
  bit         m_occ[4];
  logic [3:0] m_val[4];
  int         m_cnt = 0;

  always @(posedge clk) if (nn_start) start_cnt++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;  // >= NUM_CLASSES (10)
    endcase
  endfunction

  function automatic logic [27:0] model_hex();
    logic [27:0] h;
    for (int j = 0; j < 4; j++) h[7*j +: 7] = m_occ[j] ? seg7(m_val[j]) : 7'b1111111;
    return h;
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 4; j++) begin m_occ[j] = 1'b0; m_val[j] = '0; end
    m_cnt = 0;
  endtask

  // Raise the switch and wait (bounded) for the ARM cycle; returns at the
  // negedge where nn_start is high, with start_req dropped again.
  task automatic start_and_arm();
    bit seen = 1'b0;
    start_req = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (nn_start) seen = 1'b1;
    end
    chk("arm_seen", seen, 1);
    starts_exp++;
    start_req = 1'b0;
  endtask

  // From the ARM negedge: k negedges lands on WAIT counter k-1, then done.
  task automatic finish_inf(input logic [3:0] v, input int k, input bit noisy);
    logic [3:0] e;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (noisy && i < k - 2) begin clear = 1'b1; start_req = i[0]; end
      else begin clear = 1'b0; start_req = 1'b0; end
    end
    chk("busy_wait", busy, 1);
    nn_done = 1'b1; nn_argmax = v; exp_q.push_back(v);
    @(negedge clk);
    nn_done = 1'b0;
    chk("busy_cap", busy, 0);
    @(negedge clk);
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int j = 3; j > 0; j--) begin m_occ[j] = m_occ[j-1]; m_val[j] = m_val[j-1]; end
      m_occ[0] = 1'b1; m_val[0] = e;
      if (m_cnt < 4) m_cnt++;
      chk("slot0", hex_out[6:0], seg7(e));
    end
    chk("hex", hex_out, model_hex());
    chk("count", result_count, m_cnt);
    chk("nstart", start_cnt, starts_exp);
    chk("err_clr", timeout_err, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    chk("rst_hex", hex_out, 28'hFFFFFFF);
    chk("rst_cnt", result_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", nn_start, 0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    // single inference returning 7
    start_and_arm();
    finish_inf(4'd7, 12, 1'b0);
    chk("seven", hex_out[6:0], 7'b1111000);

    // five results into four slots
    for (int i = 1; i <= 5; i++) begin
      start_and_arm();
      finish_inf(4'(i), i, 1'b0);
    end
    chk("hist5", hex_out, {seg7(4'd2), seg7(4'd3), seg7(4'd4), seg7(4'd5)});
    chk("sat", result_count, 4);

    // done on the last timeout cycle wins
    start_and_arm();
    finish_inf(4'd6, 16, 1'b0);

    // timeout: 16 WAIT cycles then ERROR
    start_and_arm();
    repeat (16) @(negedge clk);
    chk("to_last_wait", busy, 1);
    chk("to_no_err_yet", timeout_err, 0);
    @(negedge clk);
    chk("to_err", timeout_err, 1);
    chk("to_busy", busy, 0);
    chk("to_hist", hex_out, model_hex());
    repeat (3) @(negedge clk);
    chk("to_sticky", timeout_err, 1);
    start_and_arm();
    chk("to_recover", timeout_err, 0);
    finish_inf(4'd9, 2, 1'b0);

    // out-of-range class, then clear in IDLE
    start_and_arm();
    finish_inf(4'd12, 3, 1'b0);
    chk("dash", hex_out[6:0], 7'b0111111);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    chk("clr_hex", hex_out, 28'hFFFFFFF);
    chk("clr_cnt", result_count, 0);

    // clear coincident with the start event in IDLE
    start_and_arm();
    finish_inf(4'd3, 2, 1'b0);
    repeat (2) @(negedge clk);
    start_req = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("cs_arm", nn_start, 1);
    chk("cs_cnt", result_count, 0);
    starts_exp++;
    start_req = 1'b0;
    model_clear();
    finish_inf(4'd8, 4, 1'b0);

    // switch toggling and clear during WAIT are ignored
    start_and_arm();
    finish_inf(4'd4, 10, 1'b1);
    chk("noisy_cnt", result_count, 2);

    // reset mid-WAIT with switch held high and a late done
    start_and_arm();
    repeat (3) @(negedge clk);
    start_req = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mr_start", nn_start, 0);
    chk("mr_busy", busy, 0);
    chk("mr_err", timeout_err, 0);
    chk("mr_cnt", result_count, 0);
    chk("mr_hex", hex_out, 28'hFFFFFFF);
    model_clear();
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    nn_done = 1'b1; nn_argmax = 4'd4;
    repeat (8) @(negedge clk);
    chk("held_nstart", start_cnt, starts_exp);
    chk("held_busy", busy, 0);
    chk("late_done_cnt", result_count, 0);
    chk("late_done_hex", hex_out, 28'hFFFFFFF);
    nn_done = 1'b0;
    start_req = 1'b0;
    repeat (3) @(negedge clk);
    start_and_arm();
    finish_inf(4'd2, 2, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nn_inference_sequencer.md
NN_INFERENCE_SEQUENCER -- requirements
Module: nn_inference_sequencer

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10, number of valid class indices (2..16).
REQ-002 SHALL have parameter CLASS_W, default 4, argmax bus width; 2^CLASS_W >= NUM_CLASSES.
REQ-003 SHALL have parameter HIST_DEPTH, default 4, number of result slots and 7-segment digits (1..6).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1048576, maximum cycles to wait for done (>= 2).
REQ-005 SHALL have port clk, input, 1, single clock domain; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port start_req, input, 1, asynchronous level request from a switch.
REQ-008 SHALL have port clear, input, 1, synchronous level request to empty the result history.
REQ-009 SHALL have port nn_done, input, 1, inference-complete level from the network core.
REQ-010 SHALL have port nn_argmax, input, CLASS_W, predicted class; sampled only when nn_done is high.
REQ-011 SHALL have port nn_start, output, 1, one-cycle start pulse to the network core.
REQ-012 SHALL have port busy, output, 1, high in ARM and WAIT.
REQ-013 SHALL have port timeout_err, output, 1, sticky flag set when an inference times out.
REQ-014 SHALL have port result_count, output, 3, number of occupied slots, saturating at HIST_DEPTH.
REQ-015 SHALL have port hex_out, output, 7*HIST_DEPTH, active-low segments; slot k occupies bits [7k+6:7k]; slot 0 is the newest result.

Function
REQ-016 SHALL pass start_req through a 2-flop synchronizer; a start event is a 0->1 transition of the synchronized signal.
REQ-017 SHALL implement states IDLE, ARM, WAIT, CAPTURE, ERROR.
REQ-018 IDLE: a start event SHALL move to ARM; nn_done in IDLE SHALL be ignored.
REQ-019 ARM: nn_start SHALL be 1 for exactly this one cycle; the timeout counter SHALL be cleared to 0; next state WAIT unconditionally.
REQ-020 WAIT: the counter SHALL increment each cycle; nn_done=1 SHALL move to CAPTURE; otherwise, when the counter reaches TIMEOUT_CYCLES-1, SHALL move to ERROR.
REQ-021 If nn_done=1 in the cycle the counter reaches TIMEOUT_CYCLES-1, done SHALL win: CAPTURE, no error.
REQ-022 CAPTURE: SHALL shift slots up (slot k -> k+1, oldest discarded), write nn_argmax (registered on WAIT exit) into slot 0, increment result_count (saturating), and return to IDLE.
REQ-023 ERROR: SHALL set timeout_err=1; a start event SHALL clear timeout_err and go to ARM; clear=1 SHALL clear timeout_err and go to IDLE.
REQ-024 Start events while in ARM, WAIT, or CAPTURE SHALL be ignored and SHALL NOT be queued.
REQ-025 clear=1 in IDLE or ERROR SHALL empty all slots and set result_count=0 in the next cycle; clear in ARM, WAIT, or CAPTURE SHALL be ignored.
REQ-026 clear and a start event together in IDLE: clear SHALL take effect and the start SHALL also be honored (IDLE->ARM with an empty history).
REQ-027 Each slot SHALL hold {occupied, value}; an empty slot SHALL display 7'b1111111.
REQ-028 Values 0-9 SHALL use encodings 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-029 Values 10-15 below NUM_CLASSES SHALL display hex A-F: 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-030 Any captured value >= NUM_CLASSES SHALL display 7'b0111111 (dash).
REQ-031 hex_out SHALL be decoded combinationally from registered slot contents.

Reset
REQ-032 resetn=0 SHALL asynchronously force: state IDLE, nn_start=0, busy=0, timeout_err=0, result_count=0, all slots empty (hex_out all ones), counter 0, synchronizer flops 0.
REQ-033 Reset asserted mid-WAIT SHALL abandon the inference with no slot written; a later nn_done SHALL be ignored (state IDLE).
REQ-034 After resetn deasserts, a start_req already high SHALL NOT create a start event until it falls and rises again.

Verification
REQ-035 Reset, raise start_req, assert nn_done with nn_argmax=7 after 20 cycles -> one nn_start pulse, busy high until CAPTURE, hex_out[6:0]=1111000, result_count=1.
REQ-036 Five inferences returning 1,2,3,4,5 with HIST_DEPTH=4 -> slots 0..3 show 5,4,3,2; result_count=4.
REQ-037 TIMEOUT_CYCLES=16, no nn_done -> ERROR after 16 WAIT cycles, timeout_err=1, history unchanged; then start event -> timeout_err=0, new nn_start pulse.
REQ-038 nn_done coincident with the final timeout cycle -> CAPTURE, timeout_err stays 0.
REQ-039 NUM_CLASSES=10, nn_argmax=12 captured -> slot 0 shows 0111111; clear in IDLE -> hex_out all ones, result_count=0.
REQ-040 start_req toggled and clear asserted during WAIT -> no extra nn_start pulse, history not cleared; reset asserted mid-WAIT -> all outputs at reset values immediately.
